// File: rtl/alu_pkg.sv
// Shared opcode encoding and width constant for the execute-stage ALU.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 32;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_MUL  = 4'd2,
      OP_DIV  = 4'd3,
      OP_MOD  = 4'd4,
      OP_AND  = 4'd5,
      OP_OR   = 4'd6,
      OP_XOR  = 4'd7,
      OP_SLL  = 4'd8,
      OP_SRL  = 4'd9,
      OP_SRA  = 4'd10,
      OP_SLT  = 4'd11,
      OP_SLTU = 4'd12
   } alu_op_e;

endpackage

// File: rtl/alu_divmod.sv
// Combinational signed divide/remainder with divide-by-zero and MIN/-1 handling.
module alu_divmod
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_quot,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_quot_err,
   output logic             o_rem_err
);

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic                    w_b_zero;
   logic                    w_min_neg1;
   logic [WIDTH-1:0]        w_safe_b;
   logic signed [WIDTH-1:0] w_q;
   logic signed [WIDTH-1:0] w_r;

   assign w_b_zero   = (i_b == '0);
   assign w_min_neg1 = (i_a == MIN_VAL) && (i_b == '1);

   // Special cases get a harmless divisor so the divider never sees /0 or MIN/-1.
   assign w_safe_b = (w_b_zero || w_min_neg1) ? WIDTH'(1) : i_b;
   assign w_q      = $signed(i_a) / $signed(w_safe_b);
   assign w_r      = $signed(i_a) % $signed(w_safe_b);

   // Select the architected result for the special cases.
   always_comb begin
      o_quot     = w_q;
      o_rem      = w_r;
      o_quot_err = 1'b0;
      o_rem_err  = 1'b0;
      if (w_b_zero) begin
         o_quot     = '1;
         o_rem      = i_a;
         o_quot_err = 1'b1;
         o_rem_err  = 1'b1;
      end else if (w_min_neg1) begin
         o_quot     = MIN_VAL;
         o_rem      = '0;
         o_quot_err = 1'b1;
      end
   end

endmodule

// File: rtl/alu_core.sv
// Single-cycle 32-bit integer ALU with registered result and flags.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             sign
);

   localparam int unsigned MSB = WIDTH - 1;
   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned PW  = 2 * WIDTH;

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [PW-1:0]    w_a_ext;
   logic [PW-1:0]    w_b_ext;
   logic [PW-1:0]    w_prod;
   logic             w_mul_ovf;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_rem;
   logic             w_quot_err;
   logic             w_rem_err;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_res;
   logic             w_ovf;

   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_ovf;
   logic             r_sign;

   assign w_sum  = a + b;
   assign w_diff = a - b;

   // Sign-extend to double width; the low half of the product is the signed product.
   assign w_a_ext   = {{WIDTH{a[MSB]}}, a};
   assign w_b_ext   = {{WIDTH{b[MSB]}}, b};
   assign w_prod    = w_a_ext * w_b_ext;
   assign w_mul_ovf = (w_prod[PW-1:MSB] != {(WIDTH+1){w_prod[MSB]}});

   assign w_shamt = b[SHW-1:0];

   alu_divmod #(.WIDTH(WIDTH)) u_divmod (
      .i_a        (a),
      .i_b        (b),
      .o_quot     (w_quot),
      .o_rem      (w_rem),
      .o_quot_err (w_quot_err),
      .o_rem_err  (w_rem_err)
   );

   // Opcode mux and overflow selection; reserved opcodes yield zero.
   always_comb begin
      w_res = '0;
      w_ovf = 1'b0;
      case (alu_op_e'(op))
         OP_ADD: begin
            w_res = w_sum;
            w_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
         end
         OP_SUB: begin
            w_res = w_diff;
            w_ovf = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
         end
         OP_MUL: begin
            w_res = w_prod[WIDTH-1:0];
            w_ovf = w_mul_ovf;
         end
         OP_DIV: begin
            w_res = w_quot;
            w_ovf = w_quot_err;
         end
         OP_MOD: begin
            w_res = w_rem;
            w_ovf = w_rem_err;
         end
         OP_AND:  w_res = a & b;
         OP_OR:   w_res = a | b;
         OP_XOR:  w_res = a ^ b;
         OP_SLL:  w_res = a << w_shamt;
         OP_SRL:  w_res = a >> w_shamt;
         OP_SRA:  w_res = $signed(a) >>> w_shamt;
         OP_SLT:  w_res = WIDTH'($signed(a) < $signed(b));
         OP_SLTU: w_res = WIDTH'(a < b);
         default: ;
      endcase
   end

   // Output register; reset overrides any op presented in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_result <= '0;
         r_zero   <= 1'b1;
         r_ovf    <= 1'b0;
         r_sign   <= 1'b0;
      end else begin
         r_result <= w_res;
         r_zero   <= (w_res == '0);
         r_ovf    <= w_ovf;
         r_sign   <= w_res[MSB];
      end
   end

   assign result   = r_result;
   assign zero     = r_zero;
   assign overflow = r_ovf;
   assign sign     = r_sign;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vector table plus randomized stream vs model.
module tb_alu_core;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  op;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic        sign;

   int checks = 0;
   int errors = 0;

   localparam longint MAXI = 64'sd2147483647;
   localparam longint MINI = -MAXI - 64'sd1;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ovf;
   } vec_t;

   vec_t vecs[25];

   alu_core dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .b        (b),
      .op       (op),
      .result   (result),
      .zero     (zero),
      .overflow (overflow),
      .sign     (sign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_out(input string name, input logic [31:0] exp_r, input logic exp_v);
      chk({name, ".result"},   result,          exp_r);
      chk({name, ".zero"},     32'(zero),       32'(exp_r == 32'd0));
      chk({name, ".sign"},     32'(sign),       32'(exp_r[31]));
      chk({name, ".overflow"}, 32'(overflow),   32'(exp_v));
   endtask

   // Reference model: evaluate each op in 64-bit signed arithmetic, then narrow.
   function automatic void model(input logic [3:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                 output logic [31:0] r, output logic v);
      longint sa;
      longint sb;
      longint t;
      int     sh;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      sh = int'(mb[4:0]);
      r  = 32'd0;
      v  = 1'b0;
      t  = 0;
      case (mop)
         4'd0: begin t = sa + sb; r = t[31:0]; v = (t > MAXI) || (t < MINI); end
         4'd1: begin t = sa - sb; r = t[31:0]; v = (t > MAXI) || (t < MINI); end
         4'd2: begin t = sa * sb; r = t[31:0]; v = (t > MAXI) || (t < MINI); end
         4'd3: begin
            if (sb == 0) begin r = 32'hFFFF_FFFF; v = 1'b1; end
            else begin t = sa / sb; r = t[31:0]; v = (t > MAXI); end
         end
         4'd4: begin
            if (sb == 0) begin r = ma; v = 1'b1; end
            else begin t = sa % sb; r = t[31:0]; end
         end
         4'd5: r = ma & mb;
         4'd6: r = ma | mb;
         4'd7: r = ma ^ mb;
         4'd8: r = ma << sh;
         4'd9: r = ma >> sh;
         4'd10: begin t = sa >>> sh; r = t[31:0]; end
         4'd11: r = (sa < sb) ? 32'd1 : 32'd0;
         4'd12: r = ({32'd0, ma} < {32'd0, mb}) ? 32'd1 : 32'd0;
         default: r = 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] rnd_operand();
      logic [31:0] corners[8];
      corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001;
      corners[2] = 32'hFFFF_FFFF; corners[3] = 32'h8000_0000;
      corners[4] = 32'h7FFF_FFFF; corners[5] = 32'h0001_0000;
      corners[6] = 32'h0000_001F; corners[7] = 32'hFFFF_FFF9;
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 7)];
      return $urandom;
   endfunction

   // Drive inputs just after an edge, then sample just after the next edge.
   task automatic apply(input logic [3:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b);
      op = t_op;
      a  = t_a;
      b  = t_b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] er;
      logic        ev;

      vecs[0]  = '{OP_ADD,  32'd10,          32'd20,          32'd30,          1'b0};
      vecs[1]  = '{OP_SUB,  32'd10,          32'd30,          32'hFFFF_FFEC,   1'b0};
      vecs[2]  = '{OP_ADD,  32'hFFFF_FFF1,   32'hFFFF_FFEC,   32'hFFFF_FFDD,   1'b0};
      vecs[3]  = '{OP_SUB,  32'd50,          32'd25,          32'd25,          1'b0};
      vecs[4]  = '{OP_ADD,  32'h7FFF_FFFF,   32'd1,           32'h8000_0000,   1'b1};
      vecs[5]  = '{OP_MUL,  32'd5,           32'd0,           32'd0,           1'b0};
      vecs[6]  = '{OP_DIV,  32'd25,          32'd5,           32'd5,           1'b0};
      vecs[7]  = '{OP_MOD,  32'd30,          32'd7,           32'd2,           1'b0};
      vecs[8]  = '{OP_DIV,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   1'b0};
      vecs[9]  = '{OP_MOD,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   1'b0};
      vecs[10] = '{OP_MUL,  32'h0001_0000,   32'h0001_0000,   32'd0,           1'b1};
      vecs[11] = '{OP_DIV,  32'd9,           32'd0,           32'hFFFF_FFFF,   1'b1};
      vecs[12] = '{OP_MOD,  32'd9,           32'd0,           32'd9,           1'b1};
      vecs[13] = '{OP_DIV,  32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   1'b1};
      vecs[14] = '{OP_MOD,  32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           1'b0};
      vecs[15] = '{OP_AND,  32'h0000_F0F0,   32'h0000_FF00,   32'h0000_F000,   1'b0};
      vecs[16] = '{OP_SRA,  32'h8000_0000,   32'd4,           32'hF800_0000,   1'b0};
      vecs[17] = '{OP_SLT,  32'hFFFF_FFFF,   32'd1,           32'd1,           1'b0};
      vecs[18] = '{OP_SLTU, 32'hFFFF_FFFF,   32'd1,           32'd0,           1'b0};
      vecs[19] = '{4'd15,   32'h1234_5678,   32'h9ABC_DEF0,   32'd0,           1'b0};
      vecs[20] = '{OP_SUB,  32'h8000_0000,   32'd1,           32'h7FFF_FFFF,   1'b1};
      vecs[21] = '{OP_SLL,  32'd1,           32'hFFFF_FFE1,   32'd2,           1'b0};
      vecs[22] = '{OP_SRL,  32'h8000_0000,   32'd31,          32'd1,           1'b0};
      vecs[23] = '{OP_OR,   32'h0000_0F00,   32'h0000_00F0,   32'h0000_0FF0,   1'b0};
      vecs[24] = '{OP_XOR,  32'h0000_FFFF,   32'h0000_0F0F,   32'h0000_F0F0,   1'b0};

      // Reset held for two cycles with random operands.
      rst_n = 1'b0;
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      @(posedge clk);
      #1;
      a = $urandom;
      b = $urandom;
      @(posedge clk);
      #1;
      check_out("reset", 32'd0, 1'b0);
      rst_n = 1'b1;

      // Directed vector table.
      foreach (vecs[i]) begin
         apply(vecs[i].op, vecs[i].a, vecs[i].b);
         check_out($sformatf("vec%0d_op%0d", i, vecs[i].op), vecs[i].res, vecs[i].ovf);
      end

      // Inputs changing between edges must not disturb the registered outputs.
      apply(OP_ADD, 32'd1, 32'd2);
      check_out("hold_pre", 32'd3, 1'b0);
      op = OP_SUB;
      a  = 32'd0;
      b  = 32'd7;
      #3;
      check_out("hold_mid", 32'd3, 1'b0);
      @(posedge clk);
      #1;
      check_out("hold_post", 32'hFFFF_FFF9, 1'b0);

      // Back-to-back random ops with a reset pulse in the middle.
      for (int i = 0; i < 40; i++) begin
         logic [3:0]  rop;
         logic [31:0] ra;
         logic [31:0] rb;
         rop = 4'($urandom_range(0, 15));
         ra  = rnd_operand();
         rb  = rnd_operand();
         if (i == 20) begin
            rst_n = 1'b0;
            apply(rop, ra, rb);
            check_out($sformatf("midreset_%0d", i), 32'd0, 1'b0);
            rst_n = 1'b1;
         end else begin
            apply(rop, ra, rb);
            model(rop, ra, rb, er, ev);
            check_out($sformatf("rnd%0d_op%0d_a%h_b%h", i, rop, ra, rb), er, ev);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 32-bit integer ALU with registered outputs, used in the project CPU execute stage.
- Performs add, subtract, multiply, divide, modulo, logic, shift and compare operations on two 32-bit operands, selected by a 4-bit opcode.
- Produces a 32-bit result plus zero, overflow and sign flags.
- Latency is 1 clock cycle; the unit accepts a new operation every cycle.

Parameters:
- WIDTH, 32, operand and result width in bits; all flag rules below are written for WIDTH=32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active low.
- a  input  WIDTH  operand A, two's complement.
- b  input  WIDTH  operand B, two's complement.
- op  input  4  operation select.
- result  output  WIDTH  registered result.
- zero  output  1  registered; 1 when result == 0.
- overflow  output  1  registered; arithmetic overflow or error flag.
- sign  output  1  registered; equals result[WIDTH-1].

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low.
  - On a clk edge with rst_n=0: result=0, zero=1, overflow=0, sign=0.
  - On a clk edge with rst_n=1: a, b and op are sampled and all outputs update together.
  - Latency is 1 cycle. There is no handshake, and back-to-back ops are allowed every cycle.
- Opcodes (all arithmetic is two's-complement signed unless stated):
  - 0 ADD: a+b. overflow = signed overflow (operands same sign, result sign differs).
  - 1 SUB: a-b. overflow = signed overflow (operands differ in sign, result sign differs from a).
  - 2 MUL: low 32 bits of the signed 64-bit product. overflow=1 when the full product does not fit in signed 32 bits.
  - 3 DIV: signed quotient, truncated toward zero.
    - b==0: result=32'hFFFFFFFF, overflow=1.
    - a==32'h80000000 and b==-1: result=32'h80000000, overflow=1.
  - 4 MOD: signed remainder; its sign follows the dividend.
    - b==0: result=a, overflow=1.
    - a==32'h80000000 and b==-1: result=0, overflow=0.
  - 5 AND, 6 OR, 7 XOR: bitwise; overflow=0.
  - 8 SLL: a << b[4:0]. 9 SRL: logical right shift. 10 SRA: arithmetic right shift. overflow=0 for all shifts; b[31:5] are ignored.
  - 11 SLT: result = (signed a < signed b) ? 1 : 0. 12 SLTU: unsigned compare. overflow=0 for both.
  - 13-15 reserved: result=0, overflow=0 (zero=1).
- Flags:
  - zero and sign are always derived from the final registered result, for every opcode.
- Divider and multiplier are purely combinational within the one cycle. No multi-cycle state and no state machine.
- A change on an input between edges has no effect until the next edge.
- Reset asserted in the same cycle as a valid op: reset wins and the op is discarded.

Decomposition:
- Shared package alu_pkg:
  - typedef enum logic [3:0] alu_op_e with OP_ADD..OP_SLTU.
  - constant ALU_WIDTH=32.
- One natural sub-module, alu_divmod: combinational signed divide/remainder, including the divide-by-zero and MIN/-1 special cases. It outputs quotient, remainder and an error flag.
- Top-level alu_core holds the opcode mux, the flag logic and the output register.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs -> result=0, zero=1, overflow=0, sign=0. Then release.
- Add/sub, each checked one cycle after apply:
  - ADD 10+20 -> 30, flags 0/0/0.
  - SUB 10-30 -> 32'hFFFFFFEC (-20), sign=1.
  - ADD -15+-20 -> -35, sign=1, overflow=0.
  - SUB 50-25 -> 25.
  - ADD 32'h7FFFFFFF+1 -> 32'h80000000, overflow=1.
- Mul/div/mod:
  - MUL 5*0 -> 0, zero=1.
  - DIV 25/5 -> 5.
  - MOD 30%7 -> 2.
  - DIV -7/2 -> -3; MOD -7%2 -> -1.
  - MUL 32'h10000*32'h10000 -> 0, overflow=1.
- Error cases:
  - DIV 9/0 -> 32'hFFFFFFFF, overflow=1.
  - MOD 9%0 -> 9, overflow=1.
  - DIV 32'h80000000/-1 -> 32'h80000000, overflow=1.
- Logic/shift/compare:
  - AND 32'hF0F0 with 32'hFF00 -> 32'hF000.
  - SRA 32'h80000000 by 4 -> 32'hF8000000.
  - SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
  - op=15 -> result=0, zero=1.
- Pipelining: apply a different op every cycle for 20 random cycles -> each output matches the golden model of the previous cycle's inputs. Also pulse rst_n low mid-stream -> outputs return to reset values on that edge.
